// File: rtl/echo_pkg.sv
// Shared definitions for the echo (Johnson) code receive path.
//   ECHO_0..ECHO_9 : 5-bit echo codes, {S1,S2,S3,S4,S5} with S1 as MSB
//   DIGIT_ILLEGAL  : digit reported for any code outside the table
//   lock_state_t   : lock state machine encoding
//   next_digit()   : BCD successor, 9 wraps to 0
package echo_pkg;

   localparam logic [4:0] ECHO_0 = 5'b11111;
   localparam logic [4:0] ECHO_1 = 5'b01111;
   localparam logic [4:0] ECHO_2 = 5'b00111;
   localparam logic [4:0] ECHO_3 = 5'b00011;
   localparam logic [4:0] ECHO_4 = 5'b00001;
   localparam logic [4:0] ECHO_5 = 5'b00000;
   localparam logic [4:0] ECHO_6 = 5'b10000;
   localparam logic [4:0] ECHO_7 = 5'b11000;
   localparam logic [4:0] ECHO_8 = 5'b11100;
   localparam logic [4:0] ECHO_9 = 5'b11110;

   localparam logic [3:0] DIGIT_ILLEGAL = 4'hF;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

   function automatic logic [3:0] next_digit(input logic [3:0] d);
      return (d >= 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/echo_decod_tabela.sv
// Combinational echo code -> BCD digit lookup. Also used as the golden
// model by the encoder bench, so it carries no state.
//   i_code    : {S1,S2,S3,S4,S5}
//   o_digit   : decoded BCD digit, DIGIT_ILLEGAL for unknown codes
//   o_illegal : 1 when i_code is not one of the ten echo codes
module echo_decod_tabela
   import echo_pkg::*;
(
   input  logic [4:0] i_code,
   output logic [3:0] o_digit,
   output logic       o_illegal
);

   always_comb begin
      o_digit   = DIGIT_ILLEGAL;
      o_illegal = 1'b0;
      case (i_code)
         ECHO_0:  o_digit = 4'd0;
         ECHO_1:  o_digit = 4'd1;
         ECHO_2:  o_digit = 4'd2;
         ECHO_3:  o_digit = 4'd3;
         ECHO_4:  o_digit = 4'd4;
         ECHO_5:  o_digit = 4'd5;
         ECHO_6:  o_digit = 4'd6;
         ECHO_7:  o_digit = 4'd7;
         ECHO_8:  o_digit = 4'd8;
         ECHO_9:  o_digit = 4'd9;
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/echo_decodificador.sv
// Echo code receiver: decodes {S1..S5} to BCD A..D through one output
// register stage with valid/ready on both sides, flags illegal codes,
// checks the +1 mod 10 digit sequence and tracks sequence lock.
//   CLK, RS              : clock, synchronous active-high reset
//   RE                   : receive enable, 0 blocks accepts (drain still allowed)
//   S1..S5, IN_VALID     : input code word, IN_READY back-pressure
//   A..D, ERR, SEQ_ERR   : registered output word, OUT_VALID / OUT_READY
//   LOCK                 : lock state machine is LOCKED
//   ERR_CNT              : saturating count of ERR and SEQ_ERR events
//
// state    | meaning
// ---------+-----------------------------------------------------------
// UNLOCKED | counting consecutive in-sequence digits toward LOCK_N
// LOCKED   | in sequence; a break or illegal code drops back to UNLOCKED
module echo_decodificador
   import echo_pkg::*;
#(
   parameter int ERR_CNT_W = 8,
   parameter int LOCK_N    = 3
)(
   input  logic                 CLK,
   input  logic                 RS,
   input  logic                 RE,
   input  logic                 S1,
   input  logic                 S2,
   input  logic                 S3,
   input  logic                 S4,
   input  logic                 S5,
   input  logic                 IN_VALID,
   output logic                 IN_READY,
   output logic                 A,
   output logic                 B,
   output logic                 C,
   output logic                 D,
   output logic                 ERR,
   output logic                 SEQ_ERR,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic                 LOCK,
   output logic [ERR_CNT_W-1:0] ERR_CNT
);

   localparam logic [3:0]           LOCK_N_C    = 4'(LOCK_N);
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_ONE = ERR_CNT_W'(1);

   lock_state_t            r_state;
   lock_state_t            w_state_nxt;
   logic [3:0]             r_run;
   logic [3:0]             w_run_nxt;
   logic [3:0]             r_prev;
   logic                   r_prev_valid;
   logic                   r_out_valid;
   logic [3:0]             r_digit;
   logic                   r_err;
   logic                   r_seq_err;
   logic [ERR_CNT_W-1:0]   r_err_cnt;

   logic [4:0]             w_code;
   logic [3:0]             w_digit;
   logic                   w_illegal;
   logic                   w_accept;
   logic                   w_in_seq;
   logic                   w_seq_err;
   logic                   w_err_inc;

   assign w_code = {S1, S2, S3, S4, S5};

   echo_decod_tabela u_tabela (
      .i_code    (w_code),
      .o_digit   (w_digit),
      .o_illegal (w_illegal)
   );

   // Ready also when the held word drains this cycle, so a full stream
   // runs at one word per clock.
   assign IN_READY = RE & ~RS & (~r_out_valid | OUT_READY);
   assign w_accept = IN_VALID & IN_READY;

   // A repeated digit is not the successor, so it counts as a break.
   assign w_in_seq = ~w_illegal & r_prev_valid & (w_digit == next_digit(r_prev));

   always_ff @(posedge CLK) begin
      if (RS) begin
         r_state <= UNLOCKED;
         r_run   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= w_run_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_run_nxt   = r_run;
      w_seq_err   = 1'b0;
      w_err_inc   = 1'b0;
      if (w_accept) begin
         case (r_state)
            UNLOCKED: begin
               if (w_illegal) begin
                  w_run_nxt = 4'd0;
                  w_err_inc = 1'b1;
               end else if (w_in_seq) begin
                  w_run_nxt = r_run + 4'd1;
               end else begin
                  w_run_nxt = 4'd1;
               end
               // Lock on the same edge the run reaches LOCK_N.
               if (!w_illegal && (w_run_nxt >= LOCK_N_C))
                  w_state_nxt = LOCKED;
            end
            LOCKED: begin
               if (w_illegal) begin
                  w_err_inc   = 1'b1;
                  w_run_nxt   = 4'd0;
                  w_state_nxt = UNLOCKED;
               end else if (!w_in_seq) begin
                  w_seq_err   = 1'b1;
                  w_err_inc   = 1'b1;
                  w_run_nxt   = 4'd1;
                  w_state_nxt = UNLOCKED;
               end
            end
            default: w_state_nxt = UNLOCKED;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RS) begin
         r_out_valid  <= 1'b0;
         r_digit      <= 4'd0;
         r_err        <= 1'b0;
         r_seq_err    <= 1'b0;
         r_prev       <= 4'd0;
         r_prev_valid <= 1'b0;
         r_err_cnt    <= '0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_digit     <= w_digit;
         r_err       <= w_illegal;
         r_seq_err   <= w_seq_err;
         if (w_illegal) begin
            r_prev_valid <= 1'b0;
         end else begin
            r_prev       <= w_digit;
            r_prev_valid <= 1'b1;
         end
         if (w_err_inc && (r_err_cnt != ERR_CNT_MAX))
            r_err_cnt <= r_err_cnt + ERR_CNT_ONE;
      end else if (OUT_READY) begin
         r_out_valid <= 1'b0;
      end
   end

   assign {A, B, C, D} = r_digit;
   assign ERR          = r_err;
   assign SEQ_ERR      = r_seq_err;
   assign OUT_VALID    = r_out_valid;
   assign LOCK         = (r_state == LOCKED);
   assign ERR_CNT      = r_err_cnt;

endmodule
